bit_reverse_deserializer: RTL
=============================

Name: bit_reverse_deserializer

Overview:
- Collects a bit-serial stream into DATA_WIDTH-bit words and presents each word in reversed bit order: the first bit received lands at dout[0], the last at dout[DATA_WIDTH-1].
- This is the serial-receive counterpart of the team's parallel bit-reverse block. It sits between a serial link front-end and word-wide datapath logic.
- Input side uses a valid/ready handshake. Output side uses a valid/ready handshake with a one-word holding register.

Parameters:
- DATA_WIDTH, 32, output word width in bits; must be ≥ 2.
- CW, $clog2(DATA_WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is valid this cycle
- din_ready  output  1  block can accept din this cycle
- dout  output  DATA_WIDTH  assembled, bit-reversed word
- dout_valid  output  1  dout holds a complete word
- dout_ready  input  1  consumer accepts dout this cycle

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values (asserted at any time, including mid-word):
  - dout = 0, dout_valid = 0.
  - Accumulator = 0, bit counter cnt = 0.
  - din_ready = 1 once resetn is deasserted.
  - Any partial word is discarded.
- Bit acceptance: a bit is accepted when din_valid && din_ready. The accepted bit is written to accumulator position cnt, then cnt increments.
- Word completion: when the accepted bit has cnt == DATA_WIDTH-1, the full word moves into the output register on the same edge.
  - The final bit is merged into the word as it moves.
  - dout_valid is set, and cnt and the accumulator clear to 0.
  - Latency: dout_valid is high the cycle after the last bit is accepted.
- Output drain: the word is consumed when dout_valid && dout_ready. dout_valid then clears unless a new word completes on the same edge, in which case dout reloads and dout_valid stays 1.
- Hold rule: dout and dout_valid stay stable while dout_valid && !dout_ready.
- Backpressure:
  - din_ready = !(cnt == DATA_WIDTH-1 && dout_valid && !dout_ready).
  - Bits 0..DATA_WIDTH-2 of the next word are always accepted while the output is held; only the completing bit stalls.
  - din_ready is combinational from state and dout_ready. It has no dependency on din_valid.
- Output-side state machine:
  - EMPTY (dout_valid = 0) → FULL when a word completes.
  - FULL → EMPTY on drain with no completion that edge.
  - FULL → FULL on drain plus completion that edge.
- Idle gaps: din_valid low leaves cnt and the accumulator unchanged. Gaps of any length are allowed.
- din is ignored whenever din_valid is low or din_ready is low.

Optional Feature:
- Macro: BITREV_DESER_FLUSH_EN.
- When defined, two ports are added:
  - flush, input, 1 bit.
  - dout_len, output, CW+1 bits: number of valid bits in dout. Reset value 0; equals DATA_WIDTH for a full word.
- Flush effect: flush high with cnt > 0 pushes the partial word to the output register.
  - Unfilled upper bits read as 0, and dout_len = cnt.
  - cnt and the accumulator clear.
- Flush only takes effect when the output slot is free or draining that cycle; otherwise flush is ignored that cycle.
- Flush with cnt == 0 does nothing.
- A bit accepted in the same cycle as flush is included in the flushed word, and dout_len counts it.
- When not defined: no flush or dout_len ports. Words are only emitted when DATA_WIDTH bits have been accepted.

Test Plan (DATA_WIDTH=8):
- Reset, then bits 1,0,0,0,0,0,0,0 on consecutive cycles with dout_ready=1 → dout=8'h01, dout_valid high for exactly 1 cycle, one cycle after the 8th bit.
- Bits 1,1,0,1,0,0,0,0 → dout=8'h0B. Then bits 0,0,0,0,0,0,0,1 → dout=8'h80.
- 16 bits back-to-back with dout_ready held 1 → two words, din_ready never low, dout_valid high on cycles 9 and 17.
- dout_ready=0 while 16 bits are offered:
  - First word held stable; din_ready drops when the 16th bit is offered (cnt=7).
  - Raise dout_ready for 1 cycle → first word drained, 16th bit accepted the same cycle, second word valid next cycle.
- Reset mid-word: 3 bits accepted, pulse resetn low asynchronously (between clock edges) → dout_valid=0, dout=0. The next 8 bits 1,0,1,0,1,0,1,0 give dout=8'h55 with no leftover bits.
- With BITREV_DESER_FLUSH_EN: bits 1,0,1, then flush=1 → dout=8'h05, dout_len=3. A following full 8-bit word reports dout_len=8.

Source files
------------

// File: rtl/bit_reverse_deserializer.sv
// Bit-serial to word deserializer: first received bit lands at dout[0].
// Optional partial-word flush with dout_len when BITREV_DESER_FLUSH_EN is defined.
module bit_reverse_deserializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
`ifdef BITREV_DESER_FLUSH_EN
  ,
  input  logic                  flush,
  output logic [$clog2(DATA_WIDTH):0] dout_len
`endif
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int LW = CW + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  last;
  logic                  slot_free;
  logic                  accept;
  logic                  complete;
  logic                  flush_go;
  logic                  emit;

  assign last      = (cnt == CW'(DATA_WIDTH - 1));
  assign slot_free = (state_q == EMPTY) || dout_ready;
  // Only the completing bit has to wait for the output slot.
  assign din_ready = !last || slot_free;
  assign accept    = din_valid && din_ready;
  assign complete  = accept && last;

`ifdef BITREV_DESER_FLUSH_EN
  logic [LW-1:0] len_q;

  assign flush_go = flush && slot_free && (cnt != '0);
  assign dout_len = len_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      len_q <= '0;
    else if (complete)
      len_q <= LW'(DATA_WIDTH);
    else if (flush_go)
      len_q <= {1'b0, cnt} + LW'(accept);
  end
`else
  assign flush_go = 1'b0;
`endif

  assign emit = complete || flush_go;

  // Accumulator with the bit accepted this cycle already merged in.
  always_comb begin
    merged = acc;
    if (accept)
      merged[cnt] = din;
  end

  // Output-slot state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Output-slot next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (emit) state_d = FULL;
      FULL:  if (dout_ready) state_d = emit ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output-slot outputs
  always_comb begin
    dout_valid = (state_q == FULL);
    dout       = dout_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      acc    <= '0;
      dout_q <= '0;
    end else if (emit) begin
      cnt    <= '0;
      acc    <= '0;
      dout_q <= merged;
    end else if (accept) begin
      cnt    <= cnt + CW'(1);
      acc    <= merged;
    end
  end

endmodule
